vga_layer_scheduler: RTL and testbench

//  Per-frame sequencer and write-port arbiter for the 320x240 3-bit framebuffer.
//  On each V_SYNC falling edge it starts the enabled draw layers in fixed order:

---
 rtl/vga_draw_pkg.sv | 13 +
 rtl/layer_next_sel.sv | 20 ++
 rtl/vga_layer_scheduler.sv | 89 ++++++++
 tb/tb_vga_layer_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// vga_draw_pkg: shared screen geometry, port widths and layer-scheduler state encoding
package vga_draw_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;
  localparam int LAYER_BG = 0;
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_NEXT} sched_state_t;
  function automatic int layer_cursor(input int num_spr);
    return num_spr + 1;
  endfunction
endpackage

// File: rtl/layer_next_sel.sv
// layer_next_sel: lowest set mask bit, either anywhere (first) or strictly above idx
module layer_next_sel #(
  parameter int L = 6
) (
  input  logic [L-1:0] mask,
  input  logic [3:0]   idx,
  input  logic         first,
  output logic [3:0]   nxt,
  output logic         found
);
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int k = L - 1; k >= 0; k--)
      if (mask[k] && (first || 4'(k) > idx)) begin
        nxt = 4'(k);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/vga_layer_scheduler.sv
// vga_layer_scheduler: per-frame layer sequencer and exclusive write-port arbiter for the VGA adapter
module vga_layer_scheduler
  import vga_draw_pkg::*;
#(
  parameter int NUM_SPR  = 4,
  parameter int WATCHDOG = 100000
) (
  input  logic                        clk,
  input  logic                        iResetn,
  input  logic                        V_SYNC,
  input  logic [NUM_SPR+1:0]          iLayerEn,
  output logic [NUM_SPR+1:0]          oGo,
  input  logic [NUM_SPR+1:0]          iDone,
  input  logic [X_W*(NUM_SPR+2)-1:0]  iX,
  input  logic [Y_W*(NUM_SPR+2)-1:0]  iY,
  input  logic [C_W*(NUM_SPR+2)-1:0]  iColor,
  input  logic [NUM_SPR+1:0]          iWe,
  output logic [X_W-1:0]              x,
  output logic [Y_W-1:0]              y,
  output logic [C_W-1:0]              color,
  output logic                        writeEn,
  output logic [3:0]                  oLayer,
  output logic                        oBusy,
  output logic                        oFrameOverrun,
  output logic                        oTimeout
);
  localparam int L = layer_cursor(NUM_SPR) + 1;
  localparam logic [16:0] WD_LAST = 17'(WATCHDOG - 1);
  sched_state_t state, state_nxt;
  logic vs_prev, frame_edge, wd_hit, done_sel, we_sel, found;
  logic [L-1:0] mask, sel_vec;
  logic [3:0] idx, nxt;
  logic [16:0] wd;
  assign frame_edge = vs_prev & ~V_SYNC;
  assign wd_hit = wd == WD_LAST;
  assign sel_vec = L'(1) << idx;
  assign done_sel = |(iDone & sel_vec);
  assign we_sel = |(iWe & sel_vec);
  assign oGo = (state == S_START) ? sel_vec : '0;
  assign oLayer = (state == S_IDLE) ? 4'd0 : idx;
  assign oBusy = state != S_IDLE;
  // A frame edge re-latches from the live enables; otherwise walk the latched mask upward
  layer_next_sel #(.L(L)) u_sel (
    .mask (frame_edge ? iLayerEn : mask),
    .idx  (idx),
    .first(frame_edge),
    .nxt  (nxt),
    .found(found)
  );
  always_comb begin
    state_nxt = state;
    if (frame_edge) state_nxt = found ? S_START : S_IDLE;
    else
      case (state)
        S_START: state_nxt = S_RUN;
        S_RUN:   state_nxt = (done_sel || wd_hit) ? S_NEXT : S_RUN;
        S_NEXT:  state_nxt = found ? S_START : S_IDLE;
        default: state_nxt = state;
      endcase
  end
  always_ff @(posedge clk or negedge iResetn)
    if (!iResetn) begin
      state <= S_IDLE;
      vs_prev <= 1'b1;
      mask <= '0;
      idx <= '0;
      wd <= '0;
      x <= '0;
      y <= '0;
      color <= '0;
      writeEn <= 1'b0;
      oFrameOverrun <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      state <= state_nxt;
      vs_prev <= V_SYNC;
      if (frame_edge) mask <= iLayerEn;
      if ((frame_edge || state == S_NEXT) && found) idx <= nxt;
      wd <= (state == S_START) ? '0 : (state == S_RUN && !(&wd)) ? wd + 1'b1 : wd;
      writeEn <= state == S_RUN && we_sel;
      if (state == S_RUN) begin
        x <= X_W'(iX >> (X_W * idx));
        y <= Y_W'(iY >> (Y_W * idx));
        color <= C_W'(iColor >> (C_W * idx));
      end
      oFrameOverrun <= frame_edge && state != S_IDLE;
      oTimeout <= state == S_RUN && wd_hit && !frame_edge;
    end
endmodule

// File: tb/tb_vga_layer_scheduler.sv
// tb_vga_layer_scheduler: frame sequencing, port arbitration, watchdog, overrun and reset checks
module tb_vga_layer_scheduler;
  localparam int L = 6;
  localparam int WD = 50;
  typedef struct { logic [L-1:0] en; int dly[L]; int n_go; int n_to; } vec_t;
  typedef struct { int val; int cyc; } ev_t;

  logic clk = 1'b0, iResetn = 1'b0, V_SYNC = 1'b1;
  logic [L-1:0] iLayerEn = '0, iDone = '0, iWe = '0;
  logic [9*L-1:0] iX = '0;
  logic [8*L-1:0] iY = '0;
  logic [3*L-1:0] iColor = '0;
  logic [L-1:0] oGo;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic [3:0] oLayer;
  logic writeEn, oBusy, oFrameOverrun, oTimeout;

  int cyc = 0, checks = 0, errors = 0, n_go = 0, n_to = 0, bad = 0;
  int cur_dly[L];
  int cnt[L];
  logic [L-1:0] lat_en = '0;
  ev_t go_q[$], to_q[$], ov_q[$];
  ev_t e;
  vec_t tbl[5];
  vec_t v, v2;
  int fin, c, g2, g3;

  vga_layer_scheduler #(.NUM_SPR(4), .WATCHDOG(WD)) dut (
    .clk(clk), .iResetn(iResetn), .V_SYNC(V_SYNC), .iLayerEn(iLayerEn), .oGo(oGo),
    .iDone(iDone), .iX(iX), .iY(iY), .iColor(iColor), .iWe(iWe),
    .x(x), .y(y), .color(color), .writeEn(writeEn), .oLayer(oLayer),
    .oBusy(oBusy), .oFrameOverrun(oFrameOverrun), .oTimeout(oTimeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk_ev(input int val, input int cy);
    ev_t r;
    r.val = val;
    r.cyc = cy;
    return r;
  endfunction

  function automatic vec_t mk(input logic [L-1:0] en, input int d0, d1, d2, d3, d4, d5,
                              input int ng, input int nt);
    vec_t r;
    r.en = en;
    r.dly[0] = d0; r.dly[1] = d1; r.dly[2] = d2;
    r.dly[3] = d3; r.dly[4] = d4; r.dly[5] = d5;
    r.n_go = ng;
    r.n_to = nt;
    return r;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scoreboard pops, foreign-layer watch and the layer painters (done dly-1 cycles after go)
  initial forever begin
    @(negedge clk);
    if (oGo != 0) begin
      n_go++;
      if (go_q.size() == 0) chk("go_unexpected", oGo, 0);
      else begin
        e = go_q.pop_front();
        chk("go_layer", oGo, 64'(1) << e.val);
        chk("go_cyc", cyc, e.cyc);
      end
    end
    if (oTimeout) begin
      n_to++;
      if (to_q.size() == 0) chk("timeout_unexpected", 1, 0);
      else begin
        e = to_q.pop_front();
        chk("timeout_cyc", cyc, e.cyc);
      end
    end
    if (oFrameOverrun) begin
      if (ov_q.size() == 0) chk("overrun_unexpected", 1, 0);
      else begin
        e = ov_q.pop_front();
        chk("overrun_cyc", cyc, e.cyc);
      end
    end
    if (oBusy && (oLayer >= L || ((lat_en >> oLayer) & 1) == 0)) bad++;
    for (int k = 0; k < L; k++) begin
      if (oGo[k]) cnt[k] = cur_dly[k];
      else if (cnt[k] > 0) cnt[k]--;
      iDone[k] = cnt[k] == 1;
    end
  end

  // Model: go at edge+1; done at go+dly-1 (timeout at go+WD); next go two cycles after done
  task automatic start_frame(input vec_t r, input int upto, input bit ovr, output int f);
    int g, t, c0;
    c0 = cyc;
    g = c0 + 1;
    f = c0 + 1;
    n_go = 0;
    n_to = 0;
    bad = 0;
    lat_en = ovr ? (lat_en | r.en) : r.en;
    cur_dly = r.dly;
    for (int k = 0; k < L; k++)
      if (r.en[k] && k <= upto) begin
        go_q.push_back(mk_ev(k, g));
        if (r.dly[k] == 0) begin
          t = g + WD;
          to_q.push_back(mk_ev(k, t + 1));
        end else t = g + r.dly[k] - 1;
        g = t + 2;
        f = g;
      end
    if (ovr) ov_q.push_back(mk_ev(0, c0 + 1));
    iLayerEn = r.en;
    V_SYNC = 1'b0;
    fork
      begin
        repeat (2) @(negedge clk);
        V_SYNC = 1'b1;
      end
    join_none
  endtask

  task automatic finish_frame(input vec_t r, input int f);
    wait_cyc(f - 1);
    chk("busy_before_end", oBusy, r.en != 0);
    wait_cyc(f);
    chk("busy_after_end", oBusy, 0);
    wait_cyc(f + 3);
    chk("go_missing", go_q.size(), 0);
    chk("timeout_missing", to_q.size(), 0);
    chk("overrun_missing", ov_q.size(), 0);
    chk("go_count", n_go, r.n_go);
    chk("timeout_count", n_to, r.n_to);
    chk("foreign_layer", bad, 0);
    go_q.delete();
    to_q.delete();
    ov_q.delete();
  endtask

  initial begin
    tbl[0] = mk(6'b111111, 11, 11, 11, 11, 11, 11, 6, 0);
    tbl[1] = mk(6'b100001, 11, 11, 11, 11, 11, 11, 2, 0);
    tbl[2] = mk(6'b000111, 11, 0, 11, 11, 11, 11, 3, 1);
    tbl[3] = mk(6'b000000, 11, 11, 11, 11, 11, 11, 0, 0);
    tbl[4] = mk(6'b010110, 5, 2, 7, 3, 9, 4, 3, 0);
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {oGo, writeEn, oBusy, oFrameOverrun, oTimeout}, 0);
    chk("reset_pixel", {x, y, color}, 0);
    chk("reset_layer", oLayer, 0);
    iResetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", oBusy, 0);
    for (int i = 0; i < 5; i++) begin
      start_frame(tbl[i], L, 1'b0, fin);
      finish_frame(tbl[i], fin);
    end
    // Port mux: layer 0 and layer 2 both request; only the granted one reaches the adapter
    v = mk(6'b000101, 11, 11, 11, 11, 11, 11, 2, 0);
    iWe = '1;
    iX[0 +: 9] = 9'd7;    iY[0 +: 8] = 8'd9;    iColor[0 +: 3] = 3'b010;
    iX[18 +: 9] = 9'd120; iY[16 +: 8] = 8'd155; iColor[6 +: 3] = 3'b101;
    c = cyc;
    start_frame(v, L, 1'b0, fin);
    g2 = c + 13;
    wait_cyc(c + 3);
    chk("l0_x", x, 7);
    chk("l0_we", writeEn, 1);
    wait_cyc(g2 + 1);
    chk("start_we", writeEn, 0);
    chk("start_x_hold", x, 7);
    wait_cyc(g2 + 2);
    chk("l2_pixel", {x, y, color}, {9'd120, 8'd155, 3'b101});
    chk("l2_we", writeEn, 1);
    wait_cyc(g2 + 4);
    iWe = 6'b000001;
    wait_cyc(g2 + 5);
    chk("ungranted_we", writeEn, 0);
    iWe = '1;
    wait_cyc(g2 + 11);
    chk("last_px_we", writeEn, 1);
    chk("last_px_x", x, 120);
    finish_frame(v, fin);
    chk("idle_we", writeEn, 0);
    chk("idle_x_hold", x, 120);
    // Overrun: edge lands in layer 3's RUN together with its done
    v = mk(6'b111111, 11, 11, 11, 6, 11, 11, 0, 0);
    c = cyc;
    start_frame(v, 3, 1'b0, fin);
    g3 = c + 37;
    wait_cyc(g3 + 5);
    v2 = mk(6'b000001, 11, 11, 11, 11, 11, 11, 1, 0);
    start_frame(v2, L, 1'b1, fin);
    finish_frame(v2, fin);
    // Asynchronous reset in the middle of a layer's RUN
    v = mk(6'b000011, 11, 11, 11, 11, 11, 11, 0, 0);
    c = cyc;
    start_frame(v, 0, 1'b0, fin);
    wait_cyc(c + 4);
    chk("pre_reset_we", writeEn, 1);
    #2 iResetn = 1'b0;
    #1;
    chk("rst_we", writeEn, 0);
    chk("rst_go", oGo, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_layer", oLayer, 0);
    repeat (2) @(negedge clk);
    iResetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_busy", oBusy, 0);
    chk("post_reset_go_pending", go_q.size(), 0);
    start_frame(tbl[3], L, 1'b0, fin);
    finish_frame(tbl[3], fin);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
